mux_arbiter: RTL
================

# mux_arbiter

Two-requester round-robin arbiter that shares one `mux` datapath (SIZE-bit, 2:1) between requesters A and B. It selects a winner, captures the winner's data through the mux into an output register, acknowledges the winner, and presents the word downstream under a valid/ready handshake. It sits between two producers and a single shared consumer bus.

## Interface
- `SIZE`, default 1: data width in bits, passed to the `mux` instance.
- `CLK`  in  1: clock; all state changes on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `A_REQ`  in  1: requester A has a word; held until `A_ACK`.
- `A_DATA`  in  SIZE: requester A word; stable while `A_REQ`=1.
- `A_ACK`  out  1: one-cycle pulse; A's word was captured.
- `B_REQ`, `B_DATA`, `B_ACK`: same as A, for requester B.
- `OUT_VALID`  out  1: `OUT_DATA` holds a captured word.
- `OUT_DATA`  out  SIZE: captured word.
- `OUT_READY`  in  1: consumer accepts the word when `OUT_VALID`=1.
- `SEL`  out  1: registered last grant; 0=A, 1=B.
- `A_LOCK`, `B_LOCK`  in  1: present only with `MUX_ARB_LOCK_EN`.

## Operation
- FSM states: IDLE, HOLD. Internal pointer `LAST` (0=A, 1=B) records the last winner.
- IDLE, no request: stay in IDLE. `OUT_VALID`=0.
- IDLE, one request: that requester wins.
- IDLE, both requesting: the requester not equal to `LAST` wins.
- On a grant:
  - The mux select is driven combinationally with the winner.
  - At the edge: `OUT_DATA` ← mux output; `OUT_VALID` ← 1; `SEL` ← winner; `LAST` ← winner.
  - The winner's `ACK` is set high for exactly one cycle. The loser's `ACK` stays 0.
  - The FSM moves to HOLD.
- HOLD: `OUT_VALID`=1. `OUT_DATA` and `SEL` hold steady. `REQ` inputs are ignored.
- HOLD, `OUT_READY`=1: transfer completes at that edge. `OUT_VALID` ← 0; the FSM moves to IDLE.
- HOLD, `OUT_READY`=0: stay in HOLD indefinitely. There is no timeout.
- Requester rule: after seeing `ACK`=1 during a cycle, the requester drops `REQ` or presents the next word by the following edge.
- `OUT_DATA` is not cleared on transfer; it keeps the last word.
- Reset values:
  - FSM in IDLE.
  - `OUT_VALID`=0, `OUT_DATA`=0, `A_ACK`=`B_ACK`=0, `SEL`=0.
  - `LAST`=1, so A wins the first tie.
- Reset mid-HOLD: the pending word is discarded and no further `ACK` is issued. The producer has already been acknowledged, so the word is lost. This is accepted behaviour.

## Timing
- `REQ` sampled in IDLE at edge N. `OUT_VALID`, `ACK` and `SEL` are high/updated in cycle N+1.
- With `OUT_READY` tied 1: transfer at edge N+1, back in IDLE during N+2, next grant at edge N+2.
  - Peak throughput is one word per 2 cycles.
- With both requesters continuously requesting and `OUT_READY`=1, grants strictly alternate A, B, A, B.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `MUX_ARB_LOCK_EN` defined:
  - `A_LOCK`/`B_LOCK` ports exist.
  - If the winner's `LOCK`=1 at grant, a lock flag is set.
  - While the flag is set, the locked requester wins any IDLE arbitration in which its `REQ`=1, regardless of `LAST`.
  - The flag clears on a grant to the locked requester with its `LOCK`=0, or in IDLE when its `REQ`=0.
- `MUX_ARB_LOCK_EN` undefined: the lock ports and the lock flag are absent. Pure round-robin.

## Structure
- Shared package/header `mux_arb_pkg`:
  - FSM state encodings `ST_IDLE`=0, `ST_HOLD`=1.
  - Grant encodings `GNT_A`=0, `GNT_B`=1.
- One sub-module: the existing `mux` (parameter `SIZE`), instantiated with A=`A_DATA`, B=`B_DATA`, SEL=next-grant.
- Arbitration, FSM and output registers stay in `mux_arbiter`.

## Test plan
- Reset: assert `RST` for 2 cycles with `A_REQ`=`B_REQ`=1.
  - All outputs 0 during reset.
  - First grant after release goes to A.
- Single requester, SIZE=8: `A_REQ`=1, `A_DATA`=8'h5A, `OUT_READY`=1.
  - `OUT_DATA`=8'h5A, `OUT_VALID`=1 and `A_ACK`=1 one cycle later.
  - `OUT_VALID` drops the cycle after.
- Contention: both `REQ`s held, `A_DATA`=8'h11, `B_DATA`=8'h22, `OUT_READY`=1.
  - Output sequence 11, 22, 11, 22, one word every 2 cycles.
  - `SEL` toggles 0, 1, 0, 1.
- Backpressure: grant B with `OUT_READY`=0 for 5 cycles.
  - `OUT_VALID`=1, `OUT_DATA`=`B_DATA` and `SEL`=1 stay stable throughout.
  - No new `ACK` is issued.
  - Transfer completes on the first cycle `OUT_READY`=1.
- Reset during HOLD: no `ACK` after reset; `OUT_VALID`=0 on the next cycle.
- `MUX_ARB_LOCK_EN`: `A_LOCK`=1 for 3 words with `B_REQ` held.
  - Grants A, A, A, then B once A drops `LOCK`.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types for the two-requester round-robin arbiter.
// Holds the FSM state and grant encodings, the reset value of the
// last-winner pointer, and the round-robin pick helper.
package mux_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_t;

  // LAST starts at B so that A wins the first tie after reset.
  localparam gnt_t LAST_RST = GNT_B;

  // Plain round-robin choice: a lone requester wins, and a tie goes to
  // whichever side did not win last time. With no request the result is
  // don't-care; A is returned so the mux select has a defined value.
  function automatic gnt_t rr_pick(input logic a_req,
                                   input logic b_req,
                                   input gnt_t last);
    gnt_t pick;
    pick = GNT_A;
    if (a_req && b_req) begin
      pick = (last == GNT_A) ? GNT_B : GNT_A;
    end else if (b_req) begin
      pick = GNT_B;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux.sv
// SIZE-bit 2:1 multiplexer shared by the arbiter datapath.
// Ports: A, B data inputs; SEL chooses B when 1, A when 0; OUT result.
// Purely combinational: zero latency, no flow control.
module mux #(
  parameter int SIZE = 1
) (
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            SEL,
  output logic [SIZE-1:0] OUT
);

  assign OUT = SEL ? B : A;

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter in front of one shared consumer bus.
// Latency: REQ sampled in IDLE at edge N -> OUT_VALID/ACK/SEL in cycle N+1;
// peak throughput one word per two cycles.
// Backpressure: a captured word sits in HOLD until OUT_READY=1, REQs are
// ignored meanwhile, no timeout.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   A_REQ/A_DATA/A_ACK   requester A (REQ held until the one-cycle ACK)
//   B_REQ/B_DATA/B_ACK   requester B
//   OUT_VALID/OUT_DATA/OUT_READY  downstream valid/ready handshake
//   SEL                  registered last grant (0=A, 1=B)
//   A_LOCK/B_LOCK        only when MUX_ARB_LOCK_EN is defined: a winner
//                        with LOCK=1 keeps priority for its next requests
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int SIZE = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            A_REQ,
  input  logic [SIZE-1:0] A_DATA,
  output logic            A_ACK,
  input  logic            B_REQ,
  input  logic [SIZE-1:0] B_DATA,
  output logic            B_ACK,
`ifdef MUX_ARB_LOCK_EN
  input  logic            A_LOCK,
  input  logic            B_LOCK,
`endif
  output logic            OUT_VALID,
  output logic [SIZE-1:0] OUT_DATA,
  input  logic            OUT_READY,
  output logic            SEL
);

  state_t          state_q;
  state_t          state_d;
  gnt_t            last_q;
  gnt_t            grant_who;
  logic            capture;
  logic            release_out;
  logic [SIZE-1:0] mux_out;
  logic [SIZE-1:0] out_data_q;
  logic            sel_q;
  logic            a_ack_q;
  logic            b_ack_q;

  // --------------------------------------------------------------------
  // Winner selection (combinational, feeds the mux select directly)
  // --------------------------------------------------------------------
`ifdef MUX_ARB_LOCK_EN
  logic lock_q;
  gnt_t lock_who_q;
  logic lock_req;
  logic win_lock;

  assign lock_req = (lock_who_q == GNT_A) ? A_REQ  : B_REQ;
  assign win_lock = (grant_who  == GNT_A) ? A_LOCK : B_LOCK;

  always_comb begin
    grant_who = rr_pick(A_REQ, B_REQ, last_q);
    // A locked requester that is asking overrides the round-robin pointer.
    if (lock_q && lock_req) begin
      grant_who = lock_who_q;
    end
  end

  // The flag only changes in IDLE. Any IDLE cycle that does not end in a
  // grant to a LOCK=1 winner clears it: either nobody asked (so the locked
  // side has REQ=0), or the grant went to the locked side with LOCK=0, or
  // it went to the other side, which can only happen when the locked side
  // has REQ=0. Hence in IDLE the flag simply becomes capture && win_lock.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_q     <= 1'b0;
      lock_who_q <= GNT_A;
    end else if (state_q == ST_IDLE) begin
      lock_q <= capture && win_lock;
      if (capture && win_lock) begin
        lock_who_q <= grant_who;
      end
    end
  end
`else
  always_comb begin
    grant_who = rr_pick(A_REQ, B_REQ, last_q);
  end
`endif

  mux #(
    .SIZE (SIZE)
  ) u_mux (
    .A   (A_DATA),
    .B   (B_DATA),
    .SEL (grant_who),
    .OUT (mux_out)
  );

  // --------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (A_REQ || B_REQ) state_d = ST_HOLD;
      ST_HOLD: if (OUT_READY)      state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------
  // FSM: decoded controls for the datapath registers
  // --------------------------------------------------------------------
  always_comb begin
    capture     = 1'b0;
    release_out = 1'b0;
    case (state_q)
      ST_IDLE: capture     = A_REQ || B_REQ;
      ST_HOLD: release_out = OUT_READY;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------
  // Datapath and grant registers
  // --------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_data_q <= '0;
      sel_q      <= 1'b0;
      last_q     <= LAST_RST;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
    end else begin
      // ACK is a pulse: only the capture edge can raise it.
      a_ack_q <= capture && (grant_who == GNT_A);
      b_ack_q <= capture && (grant_who == GNT_B);
      if (capture) begin
        out_data_q <= mux_out;
        sel_q      <= grant_who;
        last_q     <= grant_who;
      end
    end
  end

  // OUT_VALID is exactly "in HOLD", so it comes straight off the state flop.
  // OUT_DATA deliberately survives the transfer and keeps the last word.
  assign OUT_VALID = (state_q == ST_HOLD);
  assign OUT_DATA  = out_data_q;
  assign SEL       = sel_q;
  assign A_ACK     = a_ack_q;
  assign B_ACK     = b_ack_q;

  // release_out is decoded for symmetry with capture; the state register
  // already consumes OUT_READY, so nothing else needs it.
  logic unused_release;
  assign unused_release = release_out;

endmodule
